csp_channel: RTL and testbench

//  Clocked, synthesizable point-to-point CSP channel joining one sender process to one receiver.

---
 rtl/csp_pkg.sv | 10 +
 rtl/csp_chan_fsm.sv | 91 +++++++++
 rtl/csp_channel.sv | 62 ++++++
 tb/tb_csp_channel.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/csp_pkg.sv
// Shared types and defaults for the CSP channel slice.
package csp_pkg;

    typedef enum logic {P4PHASE_BD, P2PHASE_BD} hs_protocol_e;

    typedef enum logic [1:0] {IDLE, OFFER, DONE} chan_state_e;

    localparam int unsigned CSP_DEFAULT_WIDTH = 11;

endpackage

// File: rtl/csp_chan_fsm.sv
// Handshake sequencer for one CSP channel: tracks state, drives the
// registered rcv_req/snd_ack, and follows request/ack transitions in
// 2-phase mode. Emits a capture strobe (payload must be latched) and a
// token_done strobe (Send/Receive pair completes on this edge).
module csp_chan_fsm
    import csp_pkg::*;
#(
    parameter hs_protocol_e HS_PROTOCOL = P4PHASE_BD
) (
    input  logic clk,
    input  logic rst,
    input  logic snd_req,
    input  logic rcv_ack,
    output logic snd_ack,
    output logic rcv_req,
    output logic capture,
    output logic token_done
);

    chan_state_e state;
    logic        snd_req_seen;
    logic        rcv_ack_seen;
    logic        req_pending;
    logic        ack_pending;

    // Decode pending request/ack events and the strobes the top level consumes.
    always_comb begin
        req_pending = 1'b0;
        ack_pending = 1'b0;
        if (HS_PROTOCOL == P2PHASE_BD) begin
            req_pending = snd_req ^ snd_req_seen;
            ack_pending = rcv_ack ^ rcv_ack_seen;
        end else begin
            req_pending = snd_req;
            ack_pending = rcv_ack;
        end
        capture    = (state == IDLE)  && req_pending;
        token_done = (state == OFFER) && ack_pending;
    end

    // Channel state machine with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            snd_ack      <= 1'b0;
            rcv_req      <= 1'b0;
            snd_req_seen <= 1'b0;
            rcv_ack_seen <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Keep the ack tracker in step so that ack toggles seen
                    // while idle never count as a completion later.
                    rcv_ack_seen <= rcv_ack;
                    if (capture) begin
                        snd_req_seen <= snd_req;
                        state        <= OFFER;
                        if (HS_PROTOCOL == P2PHASE_BD) begin
                            rcv_req <= ~rcv_req;
                        end else begin
                            rcv_req <= 1'b1;
                        end
                    end
                end
                OFFER: begin
                    if (token_done) begin
                        rcv_ack_seen <= rcv_ack;
                        if (HS_PROTOCOL == P2PHASE_BD) begin
                            snd_ack <= ~snd_ack;
                            state   <= IDLE;
                        end else begin
                            snd_ack <= 1'b1;
                            rcv_req <= 1'b0;
                            state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (!snd_req && !rcv_ack) begin
                        snd_ack <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/csp_channel.sv
// Point-to-point CSP channel: bundled-data req/ack rendezvous between one
// sender and one receiver, with a registered payload that stays stable while
// rcv_req is asserted.
// Optional build macro CSP_CHANNEL_STATS_EN adds the tok_cnt port and a
// 32-bit completed-token counter.
module csp_channel
    import csp_pkg::*;
#(
    parameter int unsigned  WIDTH       = CSP_DEFAULT_WIDTH,
    parameter hs_protocol_e HS_PROTOCOL = P4PHASE_BD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             snd_req,
    input  logic [WIDTH-1:0] snd_data,
    output logic             snd_ack,
    output logic             rcv_req,
    output logic [WIDTH-1:0] rcv_data,
    input  logic             rcv_ack
`ifdef CSP_CHANNEL_STATS_EN
    ,
    output logic [31:0]      tok_cnt
`endif
);

    logic capture;
    logic token_done;

    csp_chan_fsm #(
        .HS_PROTOCOL (HS_PROTOCOL)
    ) u_fsm (
        .clk        (clk),
        .rst        (rst),
        .snd_req    (snd_req),
        .rcv_ack    (rcv_ack),
        .snd_ack    (snd_ack),
        .rcv_req    (rcv_req),
        .capture    (capture),
        .token_done (token_done)
    );

    // Payload register: loads only when a token is accepted in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            rcv_data <= '0;
        end else if (capture) begin
            rcv_data <= snd_data;
        end
    end

`ifdef CSP_CHANNEL_STATS_EN
    // Completed-token counter, wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            tok_cnt <= '0;
        end else if (token_done) begin
            tok_cnt <= tok_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_csp_channel.sv
// Directed bench for csp_channel: a 4-phase instance driven from a vector
// table plus hand sequences, and a 2-phase instance driven by hand.
module tb_csp_channel;
    import csp_pkg::*;

    localparam int unsigned W = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4-phase instance signals
    logic         rst4, req4, ack4, sa4, rr4;
    logic [W-1:0] data4, rd4;
    // 2-phase instance signals
    logic         rst2, req2, ack2, sa2, rr2;
    logic [W-1:0] data2, rd2;
`ifdef CSP_CHANNEL_STATS_EN
    logic [31:0]  cnt4, cnt2;
`endif

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    csp_channel #(
        .WIDTH       (W),
        .HS_PROTOCOL (P4PHASE_BD)
    ) dut4 (
        .clk      (clk),
        .rst      (rst4),
        .snd_req  (req4),
        .snd_data (data4),
        .snd_ack  (sa4),
        .rcv_req  (rr4),
        .rcv_data (rd4),
        .rcv_ack  (ack4)
`ifdef CSP_CHANNEL_STATS_EN
        ,
        .tok_cnt  (cnt4)
`endif
    );

    csp_channel #(
        .WIDTH       (W),
        .HS_PROTOCOL (P2PHASE_BD)
    ) dut2 (
        .clk      (clk),
        .rst      (rst2),
        .snd_req  (req2),
        .snd_data (data2),
        .snd_ack  (sa2),
        .rcv_req  (rr2),
        .rcv_data (rd2),
        .rcv_ack  (ack2)
`ifdef CSP_CHANNEL_STATS_EN
        ,
        .tok_cnt  (cnt2)
`endif
    );

    typedef struct {
        logic         rst;
        logic         req;
        logic [W-1:0] data;
        logic         ack;
        logic         exp_rr;
        logic         exp_sa;
        logic [W-1:0] exp_d;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock and land 1 time unit after the edge for sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic token4(input logic [W-1:0] d);
        req4 = 1'b1; data4 = d; ack4 = 1'b0;
        step();
        chk("b2b_rcv_req", {31'd0, rr4}, 32'd1);
        chk("b2b_rcv_data", {21'd0, rd4}, {21'd0, d});
        ack4 = 1'b1;
        step();
        chk("b2b_snd_ack_up", {30'd0, sa4, rr4}, 32'd2);
        req4 = 1'b0; ack4 = 1'b0;
        step();
        chk("b2b_snd_ack_down", {30'd0, sa4, rr4}, 32'd0);
    endtask

    initial begin
        // {rst, req, data, ack, exp_rcv_req, exp_snd_ack, exp_rcv_data}
        tbl[0]  = '{1'b1, 1'b1, 11'h781, 1'b0, 1'b0, 1'b0, 11'h000}; // reset with req high
        tbl[1]  = '{1'b1, 1'b1, 11'h781, 1'b0, 1'b0, 1'b0, 11'h000};
        tbl[2]  = '{1'b0, 1'b1, 11'h781, 1'b0, 1'b1, 1'b0, 11'h781}; // capture first edge after reset
        tbl[3]  = '{1'b0, 1'b1, 11'h7FF, 1'b0, 1'b1, 1'b0, 11'h781}; // payload change in OFFER ignored
        tbl[4]  = '{1'b0, 1'b1, 11'h7FF, 1'b1, 1'b0, 1'b1, 11'h781}; // ack -> DONE
        tbl[5]  = '{1'b0, 1'b1, 11'h7FF, 1'b0, 1'b0, 1'b1, 11'h781}; // req still high: hold DONE
        tbl[6]  = '{1'b0, 1'b0, 11'h7FF, 1'b0, 1'b0, 1'b0, 11'h781}; // both low -> IDLE
        tbl[7]  = '{1'b0, 1'b0, 11'h7FF, 1'b0, 1'b0, 1'b0, 11'h781};
        tbl[8]  = '{1'b0, 1'b0, 11'h7FF, 1'b1, 1'b0, 1'b0, 11'h781}; // ack in IDLE ignored
        tbl[9]  = '{1'b0, 1'b1, 11'h123, 1'b1, 1'b1, 1'b0, 11'h123}; // req+ack together: capture wins
        tbl[10] = '{1'b0, 1'b0, 11'h000, 1'b1, 1'b0, 1'b1, 11'h123}; // req dropped early, still delivered
        tbl[11] = '{1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 1'b0, 11'h123};

        rst4 = 1'b1; req4 = 1'b0; ack4 = 1'b0; data4 = '0;
        rst2 = 1'b1; req2 = 1'b0; ack2 = 1'b0; data2 = '0;

        for (int i = 0; i < 12; i++) begin
            rst4  = tbl[i].rst;
            req4  = tbl[i].req;
            data4 = tbl[i].data;
            ack4  = tbl[i].ack;
            step();
            chk($sformatf("tbl%0d_rcv_req", i),  {31'd0, rr4}, {31'd0, tbl[i].exp_rr});
            chk($sformatf("tbl%0d_snd_ack", i),  {31'd0, sa4}, {31'd0, tbl[i].exp_sa});
            chk($sformatf("tbl%0d_rcv_data", i), {21'd0, rd4}, {21'd0, tbl[i].exp_d});
        end

        // Back-to-back tokens from a fresh reset
        rst4 = 1'b1; req4 = 1'b0; ack4 = 1'b0;
        step();
        rst4 = 1'b0;
`ifdef CSP_CHANNEL_STATS_EN
        chk("cnt_after_reset", cnt4, 32'd0);
`endif
        token4(11'h780);
        token4(11'h781);
        token4(11'h782);
        token4(11'h784);
        token4(11'h788);
`ifdef CSP_CHANNEL_STATS_EN
        chk("cnt_five_tokens", cnt4, 32'd5);
`endif

        // Slow receiver: ack withheld for 20 cycles
        req4 = 1'b1; data4 = 11'h0F0; ack4 = 1'b0;
        step();
        chk("slow_capture", {21'd0, rd4}, 32'h0F0);
        for (int c = 0; c < 20; c++) begin
            step();
            chk("slow_hold", {30'd0, rr4, sa4}, 32'd2);
        end
        ack4 = 1'b1;
        step();
        chk("slow_ack", {30'd0, rr4, sa4}, 32'd1);
        req4 = 1'b0; ack4 = 1'b0;
        step();
        chk("slow_release", {30'd0, rr4, sa4}, 32'd0);

        // 2-phase instance
        step();
        chk("p2_reset", {19'd0, rr2, sa2, rd2}, 32'd0);
        rst2 = 1'b0;
        step();
        chk("p2_idle", {30'd0, rr2, sa2}, 32'd0);
        req2 = 1'b1; data2 = 11'h2A5;
        step();
        chk("p2_req_toggle", {30'd0, rr2, sa2}, 32'd2);
        chk("p2_data", {21'd0, rd2}, 32'h2A5);
        data2 = 11'h7FF;
        step();
        chk("p2_offer_hold", {19'd0, rr2, sa2, rd2}, {19'd0, 2'b10, 11'h2A5});
        ack2 = 1'b1;
        step();
        chk("p2_ack_toggle", {30'd0, rr2, sa2}, 32'd3);
        req2 = 1'b0; data2 = 11'h155;
        step();
        chk("p2_second_token", {19'd0, rr2, sa2, rd2}, {19'd0, 2'b01, 11'h155});
`ifdef CSP_CHANNEL_STATS_EN
        chk("p2_cnt", cnt2, 32'd1);
`endif
        rst2 = 1'b1;
        step();
        chk("p2_reset_in_offer", {19'd0, rr2, sa2, rd2}, 32'd0);
        rst2 = 1'b0; ack2 = 1'b0;
        step();
        chk("p2_after_reset", {30'd0, rr2, sa2}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
